// File: rtl/usbdev_wb_master.sv
// usbdev_wb_master: command/response to classic single-cycle Wishbone master bridge.
// Optional ACK timeout is enabled by defining USBDEV_WB_MASTER_TIMEOUT_EN.
module usbdev_wb_master #(
    parameter int ADR_W          = 14,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [ADR_W-1:0] cmd_adr,
    input  logic [31:0]      cmd_wdata,
    input  logic [3:0]       cmd_sel,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_rdata,
    output logic             rsp_err,
    output logic             wb_CYC,
    output logic             wb_STB,
    output logic             wb_WE,
    output logic [ADR_W-1:0] wb_ADR,
    output logic [31:0]      wb_DAT_MOSI,
    output logic [3:0]       wb_SEL,
    input  logic [31:0]      wb_DAT_MISO,
    input  logic             wb_ACK
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t             r_state;
    state_t             w_next;
    logic               w_accept;
    logic               w_done;
    logic               w_tmo;
    logic               r_cyc;
    logic               r_we;
    logic [ADR_W-1:0]   r_adr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_sel;
    logic               r_valid;
    logic [31:0]        r_rdata;

`ifdef USBDEV_WB_MASTER_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] r_wait;
    logic       r_err;
    assign w_tmo   = (r_state == BUS) && !wb_ACK && (r_wait == TMO_LAST);
    assign rsp_err = r_err;

    // Saturating wait counter; ACK always takes priority over the timeout.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_wait <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_accept)
                r_wait <= '0;
            else if (r_state == BUS && !wb_ACK && r_wait != 8'hFF)
                r_wait <= r_wait + 8'd1;
            if (w_done || w_tmo)
                r_err <= w_tmo;
        end
`else
    assign w_tmo   = 1'b0;
    assign rsp_err = 1'b0;
`endif

    assign cmd_ready   = (r_state == IDLE);
    assign wb_CYC      = r_cyc;
    assign wb_STB      = r_cyc;
    assign wb_WE       = r_we;
    assign wb_ADR      = r_adr;
    assign wb_DAT_MOSI = r_wdata;
    assign wb_SEL      = r_sel;
    assign rsp_valid   = r_valid;
    assign rsp_rdata   = r_rdata;

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            IDLE: begin
                w_accept = cmd_valid;
                w_next   = cmd_valid ? BUS : IDLE;
            end
            BUS: begin
                w_done = wb_ACK;
                w_next = (wb_ACK || w_tmo) ? RESP : BUS;
            end
            RESP:    w_next = rsp_ready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state <= IDLE;
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_wdata <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            r_valid <= (w_next == RESP);
            if (w_accept) begin
                r_cyc   <= 1'b1;
                r_we    <= cmd_we;
                r_adr   <= cmd_adr;
                r_wdata <= cmd_wdata;
                r_sel   <= cmd_sel;
            end
            if (w_done || w_tmo) begin
                r_cyc   <= 1'b0;
                r_rdata <= (w_tmo || r_we) ? 32'd0 : wb_DAT_MISO;
            end
        end
endmodule

// File: tb/tb_usbdev_wb_master.sv
// tb_usbdev_wb_master: directed vectors for usbdev_wb_master with hand-computed expectations.
module tb_usbdev_wb_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [13:0] cmd_adr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        wb_CYC, wb_STB, wb_WE;
    logic [13:0] wb_ADR;
    logic [31:0] wb_DAT_MOSI;
    logic [3:0]  wb_SEL;
    logic [31:0] wb_DAT_MISO = '0;
    logic        wb_ACK = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    usbdev_wb_master #(.ADR_W(14), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_wdata(cmd_wdata), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .wb_CYC(wb_CYC), .wb_STB(wb_STB), .wb_WE(wb_WE), .wb_ADR(wb_ADR),
        .wb_DAT_MOSI(wb_DAT_MOSI), .wb_SEL(wb_SEL), .wb_DAT_MISO(wb_DAT_MISO), .wb_ACK(wb_ACK)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic we, input logic [13:0] adr, input logic [31:0] wd, input logic [3:0] sel);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_wdata = wd;
        cmd_sel   = sel;
        tick();
        cmd_valid = 1'b0;
        cmd_adr   = 14'h0AAA;
        cmd_wdata = 32'h0;
        cmd_sel   = 4'h0;
        cmd_we    = ~we;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_cyc", 32'({wb_CYC, wb_STB, wb_WE}), 32'd0);
        chk("rst_rsp", 32'({rsp_valid, rsp_err}), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_bus", 32'({wb_ADR, wb_SEL}) | wb_DAT_MOSI, 32'd0);
        #10;
        rst = 1'b0;

        // Write, ACK on first bus cycle; accepted on the very first edge after reset.
        send(1'b1, 14'h0123, 32'hDEADBEEF, 4'hF);
        chk("wr_cyc_stb", 32'({wb_CYC, wb_STB}), 32'd3);
        chk("wr_we", 32'(wb_WE), 32'd1);
        chk("wr_adr", 32'(wb_ADR), 32'h0123);
        chk("wr_dat", wb_DAT_MOSI, 32'hDEADBEEF);
        chk("wr_sel", 32'(wb_SEL), 32'hF);
        chk("wr_busy", 32'(cmd_ready), 32'd0);
        wb_ACK = 1'b1;
        wb_DAT_MISO = 32'h11111111;
        tick();
        wb_ACK = 1'b0;
        chk("wr_cyc_done", 32'({wb_CYC, wb_STB}), 32'd0);
        chk("wr_rsp", 32'({rsp_valid, rsp_err}), 32'd2);
        chk("wr_rdata", rsp_rdata, 32'd0);
        consume();
        chk("wr_idle", 32'({cmd_ready, rsp_valid}), 32'd2);

        // Read at top address, ACK after 3 cycles.
        send(1'b0, 14'h3FFF, 32'h0, 4'hF);
        wb_DAT_MISO = 32'hA5A55A5A;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rd_cyc%0d", i), 32'({wb_CYC, wb_STB}), 32'd3);
            chk($sformatf("rd_adr%0d", i), 32'({wb_WE, wb_ADR}), 32'h3FFF);
            wb_ACK = (i == 2);
            tick();
        end
        wb_ACK = 1'b0;
        chk("rd_cyc_done", 32'(wb_CYC), 32'd0);
        chk("rd_rsp", 32'({rsp_valid, rsp_err}), 32'd2);
        chk("rd_rdata", rsp_rdata, 32'hA5A55A5A);

        // Held response with a stray ACK and new MISO; nothing may change.
        wb_DAT_MISO = 32'h0BADF00D;
        for (int i = 0; i < 5; i++) begin
            wb_ACK = (i == 1);
            tick();
            chk($sformatf("hold_valid%0d", i), 32'({rsp_valid, cmd_ready, wb_CYC}), 32'd4);
            chk($sformatf("hold_rdata%0d", i), rsp_rdata, 32'hA5A55A5A);
        end
        wb_ACK = 1'b0;

        // Command offered during the consuming edge must wait one more edge.
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = 14'h0042;
        cmd_sel   = 4'h3;
        consume();
        chk("hs_no_accept", 32'({cmd_ready, rsp_valid, wb_CYC}), 32'd4);
        tick();
        cmd_valid = 1'b0;
        chk("hs_accept", 32'({wb_CYC, cmd_ready}), 32'd2);
        chk("hs_adr", 32'({wb_ADR, wb_SEL}), 32'({14'h0042, 4'h3}));

        // Asynchronous reset mid-transaction.
        #2;
        rst = 1'b1;
        #1;
        chk("arst_cyc", 32'({wb_CYC, wb_STB}), 32'd0);
        chk("arst_rsp", 32'({rsp_valid, cmd_ready}), 32'd1);
        #1;
        rst = 1'b0;

        // Stray ACK in IDLE.
        wb_ACK = 1'b1;
        wb_DAT_MISO = 32'hFFFF0000;
        tick();
        wb_ACK = 1'b0;
        chk("idle_ack_state", 32'({cmd_ready, wb_CYC, rsp_valid}), 32'd4);
        chk("idle_ack_rdata", rsp_rdata, 32'd0);

        // Read completes normally after reset.
        send(1'b0, 14'h0055, 32'h0, 4'h1);
        wb_DAT_MISO = 32'h12345678;
        wb_ACK = 1'b1;
        tick();
        wb_ACK = 1'b0;
        chk("post_rst_rsp", 32'({rsp_valid, rsp_err}), 32'd2);
        chk("post_rst_rdata", rsp_rdata, 32'h12345678);
        consume();

`ifdef USBDEV_WB_MASTER_TIMEOUT_EN
        // No ACK: bus held for exactly 16 cycles, then error response.
        send(1'b0, 14'h0100, 32'h0, 4'hF);
        wb_DAT_MISO = 32'hCAFEBABE;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("tmo_cyc%0d", i), 32'(wb_CYC), 32'd1);
            tick();
        end
        chk("tmo_cyc_done", 32'(wb_CYC), 32'd0);
        chk("tmo_rsp", 32'({rsp_valid, rsp_err}), 32'd3);
        chk("tmo_rdata", rsp_rdata, 32'd0);
        consume();
        // ACK coinciding with the timeout edge wins.
        send(1'b0, 14'h0101, 32'h0, 4'hF);
        for (int i = 0; i < 16; i++) begin
            wb_ACK = (i == 15);
            tick();
        end
        wb_ACK = 1'b0;
        chk("tmo_ack_rsp", 32'({rsp_valid, rsp_err, wb_CYC}), 32'd4);
        chk("tmo_ack_rdata", rsp_rdata, 32'hCAFEBABE);
        consume();
`else
        // Without timeout the bus waits indefinitely.
        send(1'b0, 14'h0100, 32'h0, 4'hF);
        wb_DAT_MISO = 32'hCAFEBABE;
        for (int i = 0; i < 20; i++) tick();
        chk("notmo_cyc", 32'({wb_CYC, rsp_valid}), 32'd2);
        wb_ACK = 1'b1;
        tick();
        wb_ACK = 1'b0;
        chk("notmo_rsp", 32'({rsp_valid, rsp_err, wb_CYC}), 32'd4);
        chk("notmo_rdata", rsp_rdata, 32'hCAFEBABE);
        consume();
`endif
        chk("end_idle", 32'({cmd_ready, rsp_valid, wb_CYC}), 32'd4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
